// File: rtl/rprime_reader.sv
// Reads lag-windowed r'[0..M] back from scratch memory and streams (hi, lo) pairs downstream.
// Optional r'[0] sign/zero check is compiled in with `define RPRIME_R0_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing addresses, gated by free output-buffer space
// DRAIN | all reads issued, waiting for the final handshake
// DONE  | one-cycle done pulse, address and index rewound
module rprime_reader #(
  parameter logic [10:0] BASE_ADDR  = 11'd0,
  parameter int          NUM_WORDS  = 11,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [10:0] memReadAddr,
  input  logic [31:0] memIn,
  output logic        outValid,
  input  logic        outReady,
  output logic [15:0] rHi,
  output logic [15:0] rLo,
  output logic [3:0]  rIndex,
  output logic        busy,
  output logic        done,
  output logic        r0Bad
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t      state, nextState;
  logic [31:0] fifoMem [2];
  logic        wrPtr, rdPtr;
  logic [1:0]  fifoCount;
  logic        inFlight;
  logic [3:0]  issueCount;
  logic        issue, push, pop, lastPop;
  logic [2:0]  committed;

  assign outValid = (fifoCount != 2'd0);
  assign pop      = outValid && outReady;
  assign push     = inFlight;
  assign lastPop  = pop && (rIndex == 4'(NUM_WORDS - 1));
  assign rHi      = fifoMem[rdPtr][31:16];
  assign rLo      = {1'b0, fifoMem[rdPtr][15:1]};
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Space the buffer will still hold after this cycle's pop; a new issue lands one cycle later.
  assign committed = {1'b0, fifoCount} + {2'b0, inFlight} - {2'b0, pop};

  always_comb begin
    nextState = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (start) nextState = READ;
      READ: begin
        if (committed < 3'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (issueCount == 4'(NUM_WORDS - 1)) nextState = DRAIN;
        end
      end
      DRAIN: if (lastPop) nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memReadAddr <= BASE_ADDR;
      issueCount  <= 4'd0;
      inFlight    <= 1'b0;
    end else begin
      inFlight <= issue;
      if (issue) begin
        memReadAddr <= memReadAddr + 11'd1;
        issueCount  <= issueCount + 4'd1;
      end
      if (state == DRAIN && lastPop) memReadAddr <= BASE_ADDR;
      if (state == DONE) issueCount <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifoMem[0] <= 32'd0;
      fifoMem[1] <= 32'd0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      fifoCount  <= 2'd0;
      rIndex     <= 4'd0;
    end else begin
      if (push) begin
        fifoMem[wrPtr] <= memIn;
        wrPtr          <= ~wrPtr;
      end
      if (pop) begin
        rdPtr  <= ~rdPtr;
        rIndex <= lastPop ? 4'd0 : rIndex + 4'd1;
      end
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 2'd1;
        2'b01:   fifoCount <= fifoCount - 2'd1;
        default: fifoCount <= fifoCount;
      endcase
      if (state == DONE) begin
        rIndex <= 4'd0;
        wrPtr  <= 1'b0;
        rdPtr  <= 1'b0;
      end
    end
  end

`ifdef RPRIME_R0_CHECK_EN
  logic r0BadReg;

  // The word landing while exactly one read has been issued is r'[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0BadReg <= 1'b0;
    end else if (state == IDLE && start) begin
      r0BadReg <= 1'b0;
    end else if (push && issueCount == 4'd1) begin
      r0BadReg <= memIn[31] || (memIn == 32'd0);
    end
  end

  assign r0Bad = r0BadReg;
`else
  logic unusedMemLsb;
  assign unusedMemLsb = memIn[0];
  assign r0Bad        = 1'b0;
`endif

endmodule

// File: tb/tb_rprime_reader.sv
// Directed bench for rprime_reader: latency, backpressure, ignored restarts, reset mid-pass, r'[0] flag.
module tb_rprime_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        outReady = 1'b1;
  logic [10:0] memReadAddr;
  logic [31:0] memIn;
  logic        outValid;
  logic [15:0] rHi, rLo;
  logic [3:0]  rIndex;
  logic        busy, done, r0Bad;

  int nCompared = 0;
  int nMismatched = 0;

  logic [31:0] mem   [0:15];
  logic [15:0] expHi [0:10];
  logic [15:0] expLo [0:10];

  rprime_reader dut (
    .clk(clk), .reset(reset), .start(start), .memReadAddr(memReadAddr), .memIn(memIn),
    .outValid(outValid), .outReady(outReady), .rHi(rHi), .rLo(rLo), .rIndex(rIndex),
    .busy(busy), .done(done), .r0Bad(r0Bad)
  );

  always #5 clk = ~clk;

  always @(posedge clk) memIn <= mem[memReadAddr[3:0]];

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nCompared++;
    if (obs !== want) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  task automatic setWord(input int i, input logic [31:0] w, input logic [15:0] hi, input logic [15:0] lo);
    mem[i] = w;
    expHi[i] = hi;
    expLo[i] = lo;
  endtask

  // mode 0: ready high; 1: ready low in cycles 3..7; 2: ready high on odd cycles; 3: ready high plus stray starts
  task automatic runPass(input int mode, input int expFirst, input int expDone, input string name);
    int nAcc = 0;
    int firstValid = -1;
    int doneCycle = -1;
    int doneCount = 0;
    int maxOut = 0;
    int maxAddr = 0;
    int outNow;
    bit finished = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c > 1) @(negedge clk);
      case (mode)
        1:       outReady = (c < 3) || (c > 7);
        2:       outReady = (c % 2 == 1);
        default: outReady = 1'b1;
      endcase
      start = (mode == 3) && (c == 4 || c == 12);
      if (doneCycle >= 0) begin
        checkEq({name, " busy after done"}, busy, 1'b0);
        checkEq({name, " done width"}, done, 1'b0);
        checkEq({name, " addr rewound"}, memReadAddr, 11'd0);
        checkEq({name, " idx rewound"}, rIndex, 4'd0);
        checkEq({name, " valid after done"}, outValid, 1'b0);
        finished = 1'b1;
        break;
      end
      if (c == 1) checkEq({name, " busy c1"}, busy, 1'b1);
      if (outValid && firstValid < 0) firstValid = c;
      outNow = int'(memReadAddr) - nAcc;
      if (outNow > maxOut) maxOut = outNow;
      if (int'(memReadAddr) > maxAddr) maxAddr = int'(memReadAddr);
      if (outValid && outReady) begin
        if (nAcc < 11) begin
          checkEq($sformatf("%s hi%0d", name, nAcc), rHi, expHi[nAcc]);
          checkEq($sformatf("%s lo%0d", name, nAcc), rLo, expLo[nAcc]);
          checkEq($sformatf("%s idx%0d", name, nAcc), rIndex, nAcc);
        end else begin
          checkEq({name, " extra pair"}, nAcc, 10);
        end
        nAcc++;
      end
      if (done) begin
        doneCount++;
        checkEq({name, " busy in done"}, busy, 1'b1);
        if (doneCycle < 0) doneCycle = c;
      end
    end
    start = 1'b0;
    outReady = 1'b1;
    checkEq({name, " finished in budget"}, finished, 1'b1);
    checkEq({name, " pairs"}, nAcc, 11);
    checkEq({name, " done count"}, doneCount, 1);
    checkEq({name, " reads issued"}, maxAddr, 11);
    checkEq({name, " outstanding<=2"}, (maxOut <= 2), 1'b1);
    if (expFirst >= 0) checkEq({name, " first valid cycle"}, firstValid, expFirst);
    if (expDone >= 0) checkEq({name, " done cycle"}, doneCycle, expDone);
  endtask

  task automatic checkResetValues(input string name);
    checkEq({name, " addr"}, memReadAddr, 11'd0);
    checkEq({name, " valid"}, outValid, 1'b0);
    checkEq({name, " hi"}, rHi, 16'd0);
    checkEq({name, " lo"}, rLo, 16'd0);
    checkEq({name, " idx"}, rIndex, 4'd0);
    checkEq({name, " busy"}, busy, 1'b0);
    checkEq({name, " done"}, done, 1'b0);
    checkEq({name, " r0Bad"}, r0Bad, 1'b0);
  endtask

  task automatic r0Pass(input logic [31:0] w0, input logic [15:0] hi, input logic [15:0] lo,
                        input logic flagWhenEnabled, input string name);
    setWord(0, w0, hi, lo);
    runPass(0, 3, 14, name);
`ifdef RPRIME_R0_CHECK_EN
    checkEq({name, " r0Bad"}, r0Bad, flagWhenEnabled);
`else
    checkEq({name, " r0Bad"}, r0Bad, 1'b0);
    if (flagWhenEnabled === 1'bx) $display("unexpected flag");
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD0000 + i;
    setWord(0,  32'h40000000, 16'h4000, 16'h0000);
    setWord(1,  32'h3A2B1C0E, 16'h3A2B, 16'h0E07);
    setWord(2,  32'h2F00FFFF, 16'h2F00, 16'h7FFF);
    setWord(3,  32'h12340001, 16'h1234, 16'h0000);
    setWord(4,  32'h0000FFFE, 16'h0000, 16'h7FFF);
    setWord(5,  32'h7FFF8000, 16'h7FFF, 16'h4000);
    setWord(6,  32'h80010003, 16'h8001, 16'h0001);
    setWord(7,  32'h0ABC0246, 16'h0ABC, 16'h0123);
    setWord(8,  32'h55AAAA55, 16'h55AA, 16'h552A);
    setWord(9,  32'h00010100, 16'h0001, 16'h0080);
    setWord(10, 32'hFFFF7FFE, 16'hFFFF, 16'h3FFF);

    repeat (2) @(negedge clk);
    checkResetValues("por");
    reset = 1'b1;
    @(negedge clk);

    runPass(0, 3, 14, "basic");
    runPass(1, 3, 19, "backpr");
    runPass(2, 3, -1, "toggle");
    runPass(3, 3, 14, "restart");
    runPass(0, 3, 14, "repeat");

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    checkEq("midpass valid before reset", outValid, 1'b1);
    reset = 1'b0;
    #1;
    checkResetValues("midpass rst");
    @(negedge clk); reset = 1'b1;
    runPass(0, 3, 14, "afterRst");

    r0Pass(32'hFFFF8000, 16'hFFFF, 16'h4000, 1'b1, "r0neg");
    r0Pass(32'h00000000, 16'h0000, 16'h0000, 1'b1, "r0zero");
    r0Pass(32'h00000001, 16'h0000, 16'h0000, 1'b0, "r0pos");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
